// File: rtl/pipeline_sequencer_pkg.sv
// Shared defaults and helpers for the pipeline sequencer control plane.
package pipeline_sequencer_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DATA_W         = 23;

    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Handshake, flush and status bundle between the sequencer and its environment.
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
);
    localparam int OCC_W = occ_width(NUM_STAGES);

    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic                  flush;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [OCC_W-1:0]      occupancy;
    logic                  busy;
    logic [CNT_W-1:0]      done_count;

    modport master (
        output in_valid, out_ready, flush,
        input  in_ready, out_valid, stage_en, stage_valid, occupancy, busy, done_count
    );

    modport slave (
        input  in_valid, out_ready, flush,
        output in_ready, out_valid, stage_en, stage_valid, occupancy, busy, done_count
    );

endinterface

// File: rtl/pipeline_sequencer_valid_bit_stage.sv
// One valid flag of the pipeline: loads on enable, clears on flush or reset.
module valid_bit_stage (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic flush,
    input  logic d_in,
    output logic q
);
    logic valid_q;
    logic valid_d;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            valid_d = d_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign q = valid_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Valid tracking, load enables, backpressure with bubble collapsing, flush,
// occupancy and completed-item count for an N-stage datapath.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic                 clock,
    input logic                 reset,
    pipeline_sequencer_if.slave bus
);
    localparam int OCC_W = occ_width(NUM_STAGES);

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] d_in;
    logic                  accept;
    logic                  fire;
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic [CNT_W-1:0]      done_q;
    logic [CNT_W-1:0]      done_d;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        adv = '0;
        adv[NUM_STAGES-1] = ~valid[NUM_STAGES-1] | bus.out_ready;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            adv[k] = ~valid[k] | adv[k+1];
        end
    end

    assign d_in = {valid[NUM_STAGES-2:0], bus.in_valid};

    assign bus.stage_en    = adv & {NUM_STAGES{~bus.flush}};
    assign bus.in_ready    = adv[0] & ~bus.flush;
    assign bus.out_valid   = valid[NUM_STAGES-1];
    assign bus.stage_valid = valid;

    assign accept = bus.in_valid & bus.in_ready;
    assign fire   = valid[NUM_STAGES-1] & bus.out_ready;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        valid_bit_stage u_stage (
            .clock (clock),
            .reset (reset),
            .en    (bus.stage_en[k]),
            .flush (bus.flush),
            .d_in  (d_in[k]),
            .q     (valid[k])
        );
    end

    // A fire during flush still counts: the result leaves before the discard.
    always_comb begin
        occ_d  = occ_q;
        done_d = done_q + CNT_W'(fire);
        if (bus.flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(fire);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q  <= '0;
            done_q <= '0;
        end else begin
            occ_q  <= occ_d;
            done_q <= done_d;
        end
    end

    assign bus.occupancy  = occ_q;
    assign bus.busy       = |occ_q;
    assign bus.done_count = done_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Control plane for an N-stage arithmetic datapath built from chained 23-bit pipeline registers. Tracks one valid bit per stage, generates per-stage load enables, and applies output backpressure with bubble collapsing, flush and occupancy tracking. Sits between the upstream operand source and downstream consumer. The datapath registers are loaded only when this block asserts their enable.

Parameters:
NUM_STAGES, 4, number of datapath register stages controlled (>=2)
CNT_W, 16, width of the completed-item counter

Ports:
clock  input  1  rising-edge clock, single domain
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  upstream offers an operand this cycle
in_ready  output  1  sequencer accepts the operand this cycle
out_valid  output  1  last stage holds a valid result
out_ready  input  1  downstream consumes the result this cycle
flush  input  1  synchronous discard of all in-flight items
stage_en  output  NUM_STAGES  load enable for datapath stage k (bit 0 = first stage)
stage_valid  output  NUM_STAGES  valid bit per stage
occupancy  output  $clog2(NUM_STAGES+1)  number of valid stages
busy  output  1  occupancy != 0
done_count  output  CNT_W  results delivered since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high): stage_valid=0, occupancy=0, done_count=0. Consequently out_valid=0, busy=0, in_ready=1 and stage_en all 1 while reset is low and flush=0.
- Advance chain (combinational): adv[N-1] = ~v[N-1] | out_ready; adv[k] = ~v[k] | adv[k+1]. A stage loads whenever it is empty or its contents move on (bubble collapsing).
- stage_en[k] = adv[k] & ~flush. in_ready = adv[0] & ~flush. out_valid = v[N-1].
- accept = in_valid & in_ready. fire = out_valid & out_ready.
- On each edge with flush=0, for each k with adv[k]=1: v[0] <= in_valid; v[k] <= v[k-1] for k>=1. Stages with adv[k]=0 hold their contents.
- Latency: an item accepted at edge e with no stall reaches v[N-1] at edge e+N-1. out_valid is high for the cycle after that edge (N cycles after acceptance). Full throughput is 1 item/cycle while out_ready=1.
- Stall: out_ready=0 with all stages valid gives in_ready=0 and stage_en=0. Data are held without loss or duplication. With a bubble present, upstream stages keep advancing until the bubble is filled.
- occupancy <= occupancy + accept - fire, which is exactly the popcount of stage_valid. Simultaneous accept and fire leave it unchanged. It never exceeds NUM_STAGES and never underflows. The bench checks the popcount invariant.
- done_count increments on fire and wraps from 2^CNT_W-1 to 0.
- Flush (priority over everything except reset): in_ready=0, stage_en=0 during the flush cycle. At the edge, all v<=0 and occupancy<=0. A fire in the same cycle still counts in done_count, since the output is consumed before the discard. The datapath contents are left stale and are masked by valid.
- Reset mid-operation discards in-flight items immediately. No output is produced for them.
- No combinational path from in_valid to in_ready. The path from out_ready to in_ready/stage_en is combinational by design.

Decomposition:
- Shared package: default NUM_STAGES, CNT_W, datapath width 23, and an occupancy-width function (clog2).
- One sub-module: valid_bit_stage. It is a single valid flop with en, flush, d_in, q, and async reset, instantiated NUM_STAGES times in a generate loop. Advance chain and counters stay in the top level.

Test Plan:
- Reset then idle, NUM_STAGES=4: stage_valid=0000, in_ready=1, out_valid=0, occupancy=0, done_count=0.
- Single item, out_ready=1: in_valid pulsed 1 cycle -> stage_valid walks 0001,0010,0100,1000. out_valid high exactly on the 4th cycle after accept. done_count=1 after the fire.
- Streaming 10 items, in_valid=1 and out_ready=1: one accept per cycle, out_valid continuous from cycle 4 for 10 cycles, occupancy steady at 4, done_count=10.
- Backpressure: fill 4 items with out_ready=0 -> in_ready=0, stage_en=0000, occupancy=4. Raise out_ready for 1 cycle -> exactly one fire, stage_en=1111, one new accept if in_valid=1.
- Bubble collapse: items at stages 0 and 3 (stage_valid=1001), out_ready=0 -> stage 0 item advances to stage 2 over 2 cycles (stage_valid 1010 after first edge, 1100 after second), then in_ready stays 1 until stage_valid=1111.
- Flush with occupancy=3 and out_valid=1, out_ready=1 in the same cycle -> next cycle stage_valid=0000, occupancy=0, done_count +1, in_ready=0 during the flush cycle. Asserting reset mid-stream clears all outputs without waiting for a clock edge.
